// File: rtl/operand_fetch.sv
// operand_fetch: decode/operand-fetch issue stage on the read side of a
// 16-entry x 16-bit register file. Latches one instruction, reads both
// sources, stalls while a used source is flagged in-use, then captures
// the operands and offers them to execute over a valid/ready handshake.
// Issuing claims the destination register (rf_claim / rf_next_dest).
//
// Build option: define OPFETCH_BYPASS_EN to let a matching writeback
// broadcast (wb_*) override an in-use flag and supply the operand value.
// Without it the wb_* inputs are ignored.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   instr_valid, instr, instr_ready   instruction input handshake
//   rf_src1/2, rf_val1/2, rf_inuse1/2 register file read ports
//   rf_next_dest, rf_claim       destination claim strobe
//   wb_valid, wb_dest, wb_val    writeback broadcast
//   ex_valid, ex_ready, ex_op, ex_dest, ex_a, ex_b  execute handshake
//   stall_cycles                 saturating count of hazard cycles
//
// state | meaning
// IDLE  | waiting for an instruction (instr_ready=1)
// CHECK | first look at source in-use flags
// STALL | waiting for a flagged source to clear
// HOLD  | operands captured, ex_valid=1 until ex_ready
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rf_src1,
    output logic [3:0]  rf_src2,
    input  logic [15:0] rf_val1,
    input  logic [15:0] rf_val2,
    input  logic        rf_inuse1,
    input  logic        rf_inuse2,
    output logic [3:0]  rf_next_dest,
    output logic        rf_claim,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dest,
    input  logic [15:0] wb_val,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [3:0]  ex_op,
    output logic [3:0]  ex_dest,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [7:0]  stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        STALL = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q;
    logic [3:0]  ex_op_q, ex_dest_q;
    logic [15:0] ex_a_q, ex_b_q;
    logic [7:0]  stall_q, stall_d;

    logic [3:0]  op, rd, rs1, rs2;
    logic        is_nop, use1, use2;
    logic        checking, hazard, issue;
    logic        inuse1_eff, inuse2_eff;
    logic [15:0] val1, val2;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:8];
    assign rs1 = instr_q[7:4];
    assign rs2 = instr_q[3:0];

    // Opcodes 8..B read rs1 only; NOP reads nothing.
    assign is_nop = (op == 4'hF);
    assign use1   = !is_nop;
    assign use2   = !is_nop && (op[3:2] != 2'b10);

`ifdef OPFETCH_BYPASS_EN
    logic byp1, byp2;
    assign byp1       = wb_valid && (wb_dest == rs1);
    assign byp2       = wb_valid && (wb_dest == rs2);
    assign inuse1_eff = rf_inuse1 && !byp1;
    assign inuse2_eff = rf_inuse2 && !byp2;
    assign val1       = byp1 ? wb_val : rf_val1;
    assign val2       = byp2 ? wb_val : rf_val2;
`else
    logic wb_unused;
    assign wb_unused  = ^{wb_valid, wb_dest, wb_val};
    assign inuse1_eff = rf_inuse1;
    assign inuse2_eff = rf_inuse2;
    assign val1       = rf_val1;
    assign val2       = rf_val2;
`endif

    assign checking = (state_q == CHECK) || (state_q == STALL);
    assign hazard   = checking && ((use1 && inuse1_eff) || (use2 && inuse2_eff));
    assign issue    = checking && !hazard;

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        case (state_q)
            IDLE:  if (instr_valid) state_d = CHECK;
            CHECK,
            STALL: state_d = hazard ? STALL : HOLD;
            HOLD:  if (ex_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (hazard && (stall_q != 8'hFF))
            stall_d = stall_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            ex_op_q   <= '0;
            ex_dest_q <= '0;
            ex_a_q    <= '0;
            ex_b_q    <= '0;
            stall_q   <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            if ((state_q == IDLE) && instr_valid)
                instr_q <= instr;
            if (issue) begin
                ex_op_q   <= op;
                ex_dest_q <= rd;
                ex_a_q    <= use1 ? val1 : 16'h0000;
                ex_b_q    <= use2 ? val2 : 16'h0000;
            end
        end
    end

    // Read indices and claim index are only presented while checking.
    assign rf_src1      = checking ? rs1 : 4'h0;
    assign rf_src2      = checking ? rs2 : 4'h0;
    assign rf_next_dest = checking ? rd  : 4'h0;
    assign rf_claim     = issue && !is_nop;

    assign instr_ready  = (state_q == IDLE);
    assign ex_valid     = (state_q == HOLD);
    assign ex_op        = ex_op_q;
    assign ex_dest      = ex_dest_q;
    assign ex_a         = ex_a_q;
    assign ex_b         = ex_b_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_src1, rf_src2;
    logic [15:0] rf_val1, rf_val2;
    logic        rf_inuse1, rf_inuse2;
    logic [3:0]  rf_next_dest;
    logic        rf_claim;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [15:0] wb_val;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op, ex_dest;
    logic [15:0] ex_a, ex_b;
    logic [7:0]  stall_cycles;

    logic [15:0] regs [16];
    int compared = 0;
    int mismatched = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    assign rf_val1 = regs[rf_src1];
    assign rf_val2 = regs[rf_src2];

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .rf_src1(rf_src1), .rf_src2(rf_src2),
        .rf_val1(rf_val1), .rf_val2(rf_val2),
        .rf_inuse1(rf_inuse1), .rf_inuse2(rf_inuse2),
        .rf_next_dest(rf_next_dest), .rf_claim(rf_claim),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_val(wb_val),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_dest(ex_dest), .ex_a(ex_a), .ex_b(ex_b),
        .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h0101);
        regs[1] = 16'd5;
        regs[2] = 16'd7;
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        rf_inuse1 = 1'b0; rf_inuse2 = 1'b0;
        wb_valid = 1'b0; wb_dest = 4'h0; wb_val = 16'h0000; ex_ready = 1'b0;
        @(negedge clk); #1;

        // Reset values
        check("rst_instr_ready", 16'(instr_ready), 16'd1);
        check("rst_ex_valid", 16'(ex_valid), 16'd0);
        check("rst_rf_claim", 16'(rf_claim), 16'd0);
        check("rst_stall", 16'(stall_cycles), 16'd0);
        check("rst_ex_a", ex_a, 16'd0);
        check("rst_ex_op_dest", {8'h00, ex_op, ex_dest}, 16'h0000);
        check("rst_src_dest", {4'h0, rf_src1, rf_src2, rf_next_dest}, 16'h0000);
        rst = 1'b0;
        tick();

        // Basic no-hazard issue of 16'h1312
        instr_valid = 1'b1; instr = 16'h1312;
        tick();
        instr_valid = 1'b0;
        check("t1_ready_check", 16'(instr_ready), 16'd0);
        check("t1_claim", 16'(rf_claim), 16'd1);
        check("t1_next_dest", 16'(rf_next_dest), 16'd3);
        check("t1_srcs", {8'h00, rf_src1, rf_src2}, 16'h0012);
        check("t1_valid_early", 16'(ex_valid), 16'd0);
        tick();
        check("t1_ex_valid", 16'(ex_valid), 16'd1);
        check("t1_ex_a", ex_a, 16'd5);
        check("t1_ex_b", ex_b, 16'd7);
        check("t1_ex_op_dest", {8'h00, ex_op, ex_dest}, 16'h0013);
        check("t1_claim_off", 16'(rf_claim), 16'd0);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        check("t1_back_idle", 16'(instr_ready), 16'd1);
        check("t1_valid_off", 16'(ex_valid), 16'd0);

        // rs1 in-use for 4 cycles (CHECK + 3 STALL), cleared in the 5th
        rf_inuse1 = 1'b1;
        instr_valid = 1'b1; instr = 16'h1312;
        tick();
        instr_valid = 1'b0;
        check("t2_no_claim_check", 16'(rf_claim), 16'd0);
        tick(); tick(); tick();
        check("t2_valid_stalled", 16'(ex_valid), 16'd0);
        check("t2_stall_3", 16'(stall_cycles), 16'd3);
        tick();
        rf_inuse1 = 1'b0;
        regs[1] = 16'd9;
        #1;
        check("t2_claim_clear", 16'(rf_claim), 16'd1);
        check("t2_stall_4", 16'(stall_cycles), 16'd4);
        tick();
        exp_stall = 4;
        check("t2_ex_valid", 16'(ex_valid), 16'd1);
        check("t2_ex_a", ex_a, 16'd9);
        check("t2_ex_b", ex_b, 16'd7);
        check("t2_stall_final", 16'(stall_cycles), 16'(exp_stall));
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // rs2 in-use with a matching writeback in the CHECK cycle
        rf_inuse2 = 1'b1;
        instr_valid = 1'b1; instr = 16'h1312;
        tick();
        instr_valid = 1'b0;
        wb_valid = 1'b1; wb_dest = 4'h2; wb_val = 16'hBEEF;
        #1;
`ifdef OPFETCH_BYPASS_EN
        check("t3_byp_claim", 16'(rf_claim), 16'd1);
        tick();
        wb_valid = 1'b0; rf_inuse2 = 1'b0;
        check("t3_byp_valid", 16'(ex_valid), 16'd1);
        check("t3_byp_ex_b", ex_b, 16'hBEEF);
`else
        check("t3_nobyp_claim", 16'(rf_claim), 16'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b0; rf_inuse2 = 1'b0;
        #1;
        check("t3_nobyp_claim2", 16'(rf_claim), 16'd1);
        tick();
        check("t3_nobyp_valid", 16'(ex_valid), 16'd1);
        check("t3_nobyp_ex_b", ex_b, 16'd7);
`endif
        check("t3_stall", 16'(stall_cycles), 16'(exp_stall));
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // NOP issues with no claim and zero operands
        instr_valid = 1'b1; instr = 16'hF000;
        tick();
        instr_valid = 1'b0;
        check("t4_nop_claim", 16'(rf_claim), 16'd0);
        tick();
        check("t4_nop_valid", 16'(ex_valid), 16'd1);
        check("t4_nop_op", 16'(ex_op), 16'hF);
        check("t4_nop_ops", ex_a | ex_b, 16'd0);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // Opcode 9 ignores rs2 in-use flag
        regs[1] = 16'd5;
        rf_inuse2 = 1'b1;
        instr_valid = 1'b1; instr = 16'h9412;
        tick();
        instr_valid = 1'b0;
        check("t4_op9_claim", 16'(rf_claim), 16'd1);
        check("t4_op9_dest", 16'(rf_next_dest), 16'd4);
        tick();
        check("t4_op9_valid", 16'(ex_valid), 16'd1);
        check("t4_op9_ex_a", ex_a, 16'd5);
        check("t4_op9_ex_b", ex_b, 16'd0);
        check("t4_op9_stall", 16'(stall_cycles), 16'(exp_stall));

        // Backpressure: 10 cycles of ex_ready=0, a competing instruction offered
        instr_valid = 1'b1; instr = 16'h2567;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_valid", 16'(ex_valid), 16'd1);
            check("t5_hold_ready", 16'(instr_ready), 16'd0);
            check("t5_hold_a", ex_a, 16'd5);
            check("t5_hold_opdest", {8'h00, ex_op, ex_dest}, 16'h0094);
        end
        instr_valid = 1'b0;
        rf_inuse2 = 1'b0;
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        check("t5_release_idle", 16'(instr_ready), 16'd1);

        // Reset asserted during STALL
        rf_inuse1 = 1'b1;
        instr_valid = 1'b1; instr = 16'h1312;
        tick();
        instr_valid = 1'b0;
        tick();
        check("t6_in_stall", 16'(instr_ready), 16'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_idle", 16'(instr_ready), 16'd1);
        check("t6_rst_claim", 16'(rf_claim), 16'd0);
        check("t6_rst_valid", 16'(ex_valid), 16'd0);
        check("t6_rst_stall", 16'(stall_cycles), 16'd0);
        tick();
        rst = 1'b0;
        rf_inuse1 = 1'b0;
        tick();
        check("t6_after_valid", 16'(ex_valid), 16'd0);
        check("t6_after_ready", 16'(instr_ready), 16'd1);

        // Saturation of stall_cycles over 300 hazard cycles
        rf_inuse1 = 1'b1;
        instr_valid = 1'b1; instr = 16'h1312;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        check("t7_stall_254", 16'(stall_cycles), 16'd254);
        tick();
        check("t7_stall_255", 16'(stall_cycles), 16'd255);
        for (int i = 0; i < 45; i++) tick();
        check("t7_stall_sat", 16'(stall_cycles), 16'd255);
        check("t7_still_stalled", 16'(ex_valid), 16'd0);
        rf_inuse1 = 1'b0;
        tick();
        check("t7_issue_valid", 16'(ex_valid), 16'd1);
        check("t7_stall_hold", 16'(stall_cycles), 16'd255);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch issue stage on the read side of the 16-entry × 16-bit register file. Accepts one 16-bit instruction at a time and drives the file's two source-register read ports. Stalls while either source carries an in-use (pending write) flag, then captures both operands and issues them to execute over a valid/ready handshake. When it issues, it claims the destination register so the file sets that register's in-use flag.

## Interface
- No parameters; data width is 16 and register index width is 4, both fixed.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction word present
- instr  input  16  instruction word:
  - [15:12] opcode
  - [11:8] rd
  - [7:4] rs1
  - [3:0] rs2
- instr_ready  output  1  block can accept an instruction
- rf_src1, rf_src2  output  4  register file read indices
- rf_val1, rf_val2  input  16  register file read data, combinational from rf_src*
- rf_inuse1, rf_inuse2  input  1  register file in-use flags for rf_src*
- rf_next_dest  output  4  destination index being claimed
- rf_claim  output  1  one-cycle strobe; register file sets inuse[rf_next_dest]
- wb_valid  input  1  writeback broadcast valid
- wb_dest  input  4  writeback register index
- wb_val  input  16  writeback data
- ex_valid  output  1  operands valid to execute
- ex_ready  input  1  execute accepts
- ex_op  output  4  latched opcode
- ex_dest  output  4  latched rd
- ex_a, ex_b  output  16  captured operands
- stall_cycles  output  8  saturating count of STALL cycles since reset

## Operation
- FSM has four states: IDLE, CHECK, STALL, HOLD. Reset state is IDLE.
- Source usage by opcode:
  - 4'hF is a NOP: it uses no sources and claims nothing.
  - Opcodes 4'h8–4'hB use rs1 only.
  - All other opcodes use rs1 and rs2.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch instr and go to CHECK.
- CHECK and STALL:
  - rf_src1/rf_src2 are driven from the latched rs1/rs2.
  - A hazard exists when (rs1 used AND rf_inuse1) OR (rs2 used AND rf_inuse2), after the bypass rule in Configuration is applied.
  - Hazard present: go to (or stay in) STALL, and increment stall_cycles on each STALL cycle. stall_cycles saturates at 255 and never wraps.
  - No hazard: capture ex_a = rf_val1 and ex_b = rf_val2 (value 0 for an unused source), pulse rf_claim unless the opcode is NOP, and go to HOLD.
- HOLD:
  - ex_valid=1; ex_* remain stable.
  - On ex_valid && ex_ready, go to IDLE.
- rs1 == rs2 is legal; both operands read the same register.
- rd equal to a source register is legal; the claim occurs only after the operands are captured.
- WAW hazards do not stall; the register file's clear-then-set ordering on the same edge resolves them.
- Reset mid-operation: any state returns to IDLE immediately; any latched instruction is dropped; no claim is issued.

## Timing
- Reset values:
  - instr_ready=1
  - ex_valid=0, rf_claim=0, stall_cycles=0
  - ex_op, ex_dest, ex_a, ex_b = 0
  - rf_src1, rf_src2, rf_next_dest = 0
- Latency with no hazard:
  - Instruction accepted on edge N.
  - CHECK during cycle N→N+1.
  - ex_valid high from edge N+1 (HOLD).
  - Minimum of 3 cycles per instruction including the HOLD handshake.
- rf_claim is high only during the CHECK/STALL cycle whose closing edge enters HOLD. rf_next_dest equals the latched rd in that same cycle.
- Each stall adds exactly one cycle per cycle the hazard persists.
- instr_ready is 0 in CHECK, STALL and HOLD.
- ex_ready is ignored when ex_valid=0.

## Configuration
- OPFETCH_BYPASS_EN defined:
  - In CHECK/STALL, if wb_valid && wb_dest == rs1, treat rf_inuse1 as 0 and use wb_val for ex_a. rs2/ex_b follow the same rule.
  - A matching writeback therefore ends a stall in that cycle.
- OPFETCH_BYPASS_EN undefined:
  - The wb_* inputs are ignored.
  - The stall persists until the register file clears its in-use flag.

## Test plan
- Reset, then issue instr 16'h1312 with R1=5, R2=7 and no flags set → ex_valid at edge N+1, ex_a=5, ex_b=7, ex_dest=3, ex_op=1, rf_claim pulses one cycle with rf_next_dest=3.
- Same instruction with rf_inuse1=1 for 4 cycles → stall_cycles=4, ex_valid only after the flag drops, operand values taken from the clearing cycle.
- Bypass build: rf_inuse2=1 and wb_valid=1, wb_dest=2, wb_val=16'hBEEF in the CHECK cycle → zero stall cycles, ex_b=16'hBEEF.
- NOP 16'hF000, then opcode 4'h9 with rs2 flagged in-use → NOP issues with no rf_claim; opcode 9 does not stall on rs2.
- Hold ex_ready=0 for 10 cycles in HOLD → ex_* stable and instr_ready=0 throughout; assert rst during STALL → IDLE next cycle, ex_valid=0, no rf_claim.
- Force 300 stall cycles → stall_cycles saturates at 255.
